// File: rtl/div_clock_meter_pkg.sv
// -----------------------------------------------------------------------------
// div_clock_meter_pkg
//   Shared PWM-side types and constants used by the divided-clock meter.
//   - _pwm_onoff       : global PWM enable. PWM_OFF holds the PWM blocks cleared.
//   - _clkmeter_state  : meter FSM encoding.
//   - CLKMETER_*       : default sizing derived from `DIVCLK_WIDTH.
//   `DIVCLK_WIDTH is the width of the clock divider setting. It is supplied here
//   when the build does not already provide it.
// -----------------------------------------------------------------------------
`ifndef DIVCLK_WIDTH
`define DIVCLK_WIDTH 3
`endif

package div_clock_meter_pkg;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        CM_IDLE      = 2'd0,
        CM_WAIT_RISE = 2'd1,
        CM_MEAS_HIGH = 2'd2,
        CM_MEAS_LOW  = 2'd3
    } _clkmeter_state;

    localparam int CLKMETER_SYNC_STAGES = 2;

    // Counters need headroom above the largest divided phase (2**DIVCLK_WIDTH
    // cycles) so the timeout limit itself fits.
    localparam int CLKMETER_CNT_W       = `DIVCLK_WIDTH + 2;
    localparam int CLKMETER_TIMEOUT_CYC = 2 ** (`DIVCLK_WIDTH + 1);

    function automatic logic cm_busy(input _clkmeter_state st);
        return st != CM_IDLE;
    endfunction

endpackage

// File: rtl/div_clock_meter_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Synchronizes WIDTH asynchronous lanes into the clk domain through a
//   SYNC_STAGES-deep flop chain, then flags rising/falling edges of the
//   synchronized level. Usable for any asynchronous PWM-side input.
//
//   Ports
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset (all flops to 0)
//     clr      in   synchronous clear (all flops to 0)
//     din      in   WIDTH  asynchronous inputs
//     rise     out  WIDTH  s & ~s_d  (one cycle per synchronized rising edge)
//     fall     out  WIDTH  ~s & s_d  (one cycle per synchronized falling edge)
//
//   SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // sync_q[0] is the metastability-catching stage; sync_q[SYNC_STAGES-1]
    // is the usable synchronized level.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  s_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            s_d    <= '0;
        end else if (clr) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/div_clock_meter.sv
// -----------------------------------------------------------------------------
// div_clock_meter
//   Measures a divided PWM clock (meas_in, asynchronous to clk): high time,
//   low time and period in clk cycles, plus the divider setting that would
//   produce a symmetric signal of that high time.
//
//   Ports
//     clk          in   system clock
//     reset_n      in   asynchronous active-low reset
//     pwm_onoff    in   PWM_OFF synchronously clears everything, holds IDLE
//     meas_in      in   divided clock under test (asynchronous)
//     start        in   single-cycle arm request, ignored while busy
//     busy         out  state != IDLE
//     meas_valid   out  one-cycle pulse when the result registers update
//     timeout_err  out  sticky abort flag, cleared by the next accepted start
//     high_cnt     out  CNT_W  cycles meas_in was high
//     low_cnt      out  CNT_W  cycles meas_in was low
//     period_cnt   out  CNT_W  high_cnt + low_cnt (truncated to CNT_W)
//     divider_est  out  `DIVCLK_WIDTH  high_cnt - 1 (meaningful for H == L)
//
//   Build option
//     CLKMETER_CONTINUOUS_EN : after each successful measurement the closing
//     rise opens the next high phase, so results stream every period until a
//     timeout or PWM_OFF. Undefined: one measurement per start.
// -----------------------------------------------------------------------------
`ifndef DIVCLK_WIDTH
`define DIVCLK_WIDTH 3
`endif

module div_clock_meter
    import div_clock_meter_pkg::*;
#(
    parameter int CNT_W       = CLKMETER_CNT_W,
    parameter int TIMEOUT_CYC = CLKMETER_TIMEOUT_CYC,
    parameter int SYNC_STAGES = CLKMETER_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  _pwm_onoff                pwm_onoff,
    input  logic                     meas_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     meas_valid,
    output logic                     timeout_err,
    output logic [CNT_W-1:0]         high_cnt,
    output logic [CNT_W-1:0]         low_cnt,
    output logic [CNT_W-1:0]         period_cnt,
    output logic [`DIVCLK_WIDTH-1:0] divider_est
);

    localparam int               DW      = `DIVCLK_WIDTH;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYC);

    _clkmeter_state   state, state_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [CNT_W-1:0] lcnt, lcnt_nxt;
    logic [CNT_W-1:0] tmo,  tmo_nxt;
    logic             err_nxt;
    logic             valid_nxt;
    logic             latch;
    logic             clr;
    logic             rise;
    logic             fall;

    assign clr = (pwm_onoff == PWM_OFF);

    // Synchronizer latency shifts both edges equally, so phase lengths
    // counted on the synchronized level equal the raw ones.
    sync_edge_det #(
        .WIDTH       (1),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .din     (meas_in),
        .rise    (rise),
        .fall    (fall)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  state <= CM_IDLE;
        else if (clr)  state <= CM_IDLE;
        else           state <= state_nxt;
    end

    // ------------------------------------------------- next state / control
    // The counter that owns the current state is loaded with 1 on the edge
    // that opens the phase, so it equals the phase length when the closing
    // edge is seen. An edge wins over the timeout check in the same cycle.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        lcnt_nxt  = lcnt;
        tmo_nxt   = tmo;
        err_nxt   = timeout_err;
        valid_nxt = 1'b0;
        latch     = 1'b0;
        case (state)
            CM_IDLE: begin
                if (start) begin
                    state_nxt = CM_WAIT_RISE;
                    err_nxt   = 1'b0;
                    tmo_nxt   = '0;
                end
            end
            // A level already high on entry produces no rise, so a partial
            // first high phase is never counted.
            CM_WAIT_RISE: begin
                if (rise) begin
                    state_nxt = CM_MEAS_HIGH;
                    hcnt_nxt  = ONE;
                end else if (tmo == TMO_LIM) begin
                    state_nxt = CM_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_nxt   = tmo + ONE;
                end
            end
            CM_MEAS_HIGH: begin
                if (fall) begin
                    state_nxt = CM_MEAS_LOW;
                    lcnt_nxt  = ONE;
                end else if (hcnt == TMO_LIM) begin
                    state_nxt = CM_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    hcnt_nxt  = hcnt + ONE;
                end
            end
            CM_MEAS_LOW: begin
                if (rise) begin
                    latch     = 1'b1;
                    valid_nxt = 1'b1;
`ifdef CLKMETER_CONTINUOUS_EN
                    // Closing rise doubles as the next opening rise.
                    state_nxt = CM_MEAS_HIGH;
                    hcnt_nxt  = ONE;
`else
                    state_nxt = CM_IDLE;
`endif
                end else if (lcnt == TMO_LIM) begin
                    state_nxt = CM_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    lcnt_nxt  = lcnt + ONE;
                end
            end
            default: state_nxt = CM_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    // Results only move on latch; a timeout leaves them untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt        <= '0;
            lcnt        <= '0;
            tmo         <= '0;
            timeout_err <= 1'b0;
            meas_valid  <= 1'b0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            period_cnt  <= '0;
            divider_est <= '0;
        end else if (clr) begin
            hcnt        <= '0;
            lcnt        <= '0;
            tmo         <= '0;
            timeout_err <= 1'b0;
            meas_valid  <= 1'b0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            period_cnt  <= '0;
            divider_est <= '0;
        end else begin
            hcnt        <= hcnt_nxt;
            lcnt        <= lcnt_nxt;
            tmo         <= tmo_nxt;
            timeout_err <= err_nxt;
            meas_valid  <= valid_nxt;
            if (latch) begin
                high_cnt    <= hcnt;
                low_cnt     <= lcnt;
                period_cnt  <= hcnt + lcnt;
                divider_est <= DW'(hcnt - ONE);
            end
        end
    end

    assign busy = cm_busy(state);

endmodule

// File: tb/tb_div_clock_meter.sv
`ifndef DIVCLK_WIDTH
`define DIVCLK_WIDTH 3
`endif

module tb_div_clock_meter;
    import div_clock_meter_pkg::*;

    localparam int CW = `DIVCLK_WIDTH + 2;
    localparam int DW = `DIVCLK_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n;
    _pwm_onoff     pwm_onoff;
    logic          meas_in;
    logic          start;
    logic          busy;
    logic          meas_valid;
    logic          timeout_err;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] low_cnt;
    logic [CW-1:0] period_cnt;
    logic [DW-1:0] divider_est;

    int n_chk  = 0;
    int n_fail = 0;
    int vcnt   = 0;
    int v0;

    // div_clock model controls
    logic gen_en  = 1'b0;
    logic gen_lvl = 1'b0;
    int   gen_h   = 4;
    int   gen_l   = 4;

    div_clock_meter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pwm_onoff   (pwm_onoff),
        .meas_in     (meas_in),
        .start       (start),
        .busy        (busy),
        .meas_valid  (meas_valid),
        .timeout_err (timeout_err),
        .high_cnt    (high_cnt),
        .low_cnt     (low_cnt),
        .period_cnt  (period_cnt),
        .divider_est (divider_est)
    );

    always #5 clk = ~clk;

    // Divided clock: high gen_h cycles, low gen_l cycles, edges on negedge.
    initial begin
        meas_in = 1'b0;
        forever begin
            if (gen_en) begin
                meas_in = 1'b1;
                repeat (gen_h) @(negedge clk);
                meas_in = 1'b0;
                repeat (gen_l) @(negedge clk);
            end else begin
                meas_in = gen_lvl;
                @(negedge clk);
            end
        end
    end

    // meas_valid pulse counter, sampled just after each negedge.
    initial forever begin
        @(negedge clk);
        #1;
        if (meas_valid) vcnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   busy,        0);
        chk({tag, "_valid"},  meas_valid,  0);
        chk({tag, "_err"},    timeout_err, 0);
        chk({tag, "_high"},   high_cnt,    0);
        chk({tag, "_low"},    low_cnt,     0);
        chk({tag, "_period"}, period_cnt,  0);
        chk({tag, "_div"},    divider_est, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int eh, input int el,
                               input int ep, input int ed);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (meas_valid) got = 1'b1;
        end
        chk({tag, "_seen"}, got, 1);
        if (got) begin
`ifndef CLKMETER_CONTINUOUS_EN
            chk({tag, "_busy"}, busy, 0);
`endif
            chk({tag, "_high"},   high_cnt,    eh);
            chk({tag, "_low"},    low_cnt,     el);
            chk({tag, "_period"}, period_cnt,  ep);
            chk({tag, "_div"},    divider_est, ed);
        end
    endtask

    task automatic settle(input logic lvl);
        gen_en  = 1'b0;
        gen_lvl = lvl;
        repeat (40) @(negedge clk);
    endtask

    // Arm mid high phase, then land in the measured low phase.
    task automatic reach_meas_low();
        @(posedge meas_in);
        repeat (3) @(negedge clk);
        pulse_start();
        @(negedge meas_in);
        @(posedge meas_in);
        @(negedge meas_in);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        pwm_onoff = PWM_ON;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // divider=3: H=L=4
        settle(1'b0);
        gen_h = 4; gen_l = 4; gen_en = 1'b1;
        repeat (5) @(negedge clk);
        v0 = vcnt;
        pulse_start();
        wait_result("d3", 4, 4, 8, 3);
`ifndef CLKMETER_CONTINUOUS_EN
        repeat (20) @(negedge clk);
        chk("d3_once", vcnt - v0, 1);
`endif

        // divider=0: H=L=1
        settle(1'b0);
        gen_h = 1; gen_l = 1; gen_en = 1'b1;
        repeat (5) @(negedge clk);
        pulse_start();
        wait_result("d0", 1, 1, 2, 0);

        // stuck high: abort after 17 cycles in WAIT_RISE, results kept
        settle(1'b1);
        v0 = vcnt;
        pulse_start();
        repeat (16) @(negedge clk);
        chk("tmo_busy_pre", busy, 1);
        chk("tmo_err_pre", timeout_err, 0);
        @(negedge clk);
        chk("tmo_busy", busy, 0);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_high", high_cnt, 1);
        chk("tmo_low", low_cnt, 1);
        chk("tmo_period", period_cnt, 2);
        chk("tmo_div", divider_est, 0);
        chk("tmo_novalid", vcnt - v0, 0);
        repeat (10) @(negedge clk);
        chk("tmo_sticky", timeout_err, 1);

        // start mid high phase, H=L=6: partial phase ignored
        gen_h = 6; gen_l = 6; gen_en = 1'b1;
        @(posedge meas_in);
        repeat (3) @(negedge clk);
        pulse_start();
        chk("mid_err_clr", timeout_err, 0);
        wait_result("mid", 6, 6, 12, 5);

        // async reset during MEAS_LOW
        settle(1'b0);
        gen_h = 5; gen_l = 5; gen_en = 1'b1;
        reach_meas_low();
        chk("rl_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_zero("rl");
        @(negedge clk);
        reset_n = 1'b1;
        v0 = vcnt;
        repeat (15) @(negedge clk);
        chk("rl_novalid", vcnt - v0, 0);
        pulse_start();
        wait_result("rl_re", 5, 5, 10, 4);

        // PWM_OFF during MEAS_LOW: synchronous, one cycle later
        reach_meas_low();
        chk("po_busy_pre", busy, 1);
        pwm_onoff = PWM_OFF;
        #1;
        chk("po_hold_high", high_cnt, 5);
        @(negedge clk);
        chk_zero("po");
        pwm_onoff = PWM_ON;
        v0 = vcnt;
        repeat (15) @(negedge clk);
        chk("po_novalid", vcnt - v0, 0);
        pulse_start();
        wait_result("po_re", 5, 5, 10, 4);

`ifdef CLKMETER_CONTINUOUS_EN
        // continuous, divider=2: a result every 6 cycles
        settle(1'b0);
        gen_h = 3; gen_l = 3; gen_en = 1'b1;
        repeat (5) @(negedge clk);
        pulse_start();
        wait_result("c0", 3, 3, 6, 2);
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!meas_valid && n < 20);
            chk("c_gap", n, 6);
            chk("c_div", divider_est, 2);
            chk("c_busy", busy, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
